hpdmc_datactl_gen: RTL and testbench

Parametrised DDR SDRAM data-path timing controller for the hpdmc memory controller. It tracks command-to-command turnaround and generates the following:
- read/write issue permission
- per-bank precharge permission
- the bus acknowledge
- the glitch-free DQ/DQS tri-state direction

It generalises bank count, burst length, CAS latency range and write-recovery width. It adds max-merge bank timers, per-read latched CAS latency and a sticky protocol-violation flag.

---
 rtl/hpdmc_datactl_gen_if.sv | 38 +++
 rtl/hpdmc_datactl_gen.sv | 157 +++++++++++++++
 tb/tb_hpdmc_datactl_gen.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdmc_datactl_gen_if.sv
// Command and timing-status bundle between the hpdmc
// command scheduler and the data-path timing controller.
interface hpdmc_datactl_gen_if #(
  parameter int NBANKS = 4,
  parameter int CL_W   = 2,
  parameter int WR_W   = 2
);
  logic              read;
  logic              write;
  logic [NBANKS-1:0] concerned_bank;
  logic [CL_W-1:0]   tim_cas;
  logic [WR_W-1:0]   tim_wr;
  logic              read_safe;
  logic              write_safe;
  logic [NBANKS-1:0] precharge_safe;
  logic              ack;
  logic              direction;
  logic              direction_r;
  logic              violation;

  modport master (
    output read, write, concerned_bank,
    output tim_cas, tim_wr,
    input  read_safe, write_safe,
    input  precharge_safe, ack,
    input  direction, direction_r,
    input  violation
  );

  modport slave (
    input  read, write, concerned_bank,
    input  tim_cas, tim_wr,
    output read_safe, write_safe,
    output precharge_safe, ack,
    output direction, direction_r,
    output violation
  );
endinterface

// File: rtl/hpdmc_datactl_gen.sv
// DDR data-path timing: turnaround permissions, per-bank
// precharge guard, data ack, DQ/DQS direction, error flag.
module hpdmc_datactl_gen #(
  parameter int NBANKS = 4,
  parameter int BURST  = 4,
  parameter int CL_W   = 2,
  parameter int WR_W   = 2
) (
  input logic                sys_clk,
  input logic                sdram_rst_n,
  hpdmc_datactl_gen_if.slave bus
);
  localparam int D     = BURST / 2;
  localparam int CLRAW = (1 << CL_W) - 1;
  localparam int CLMAX = (CLRAW < 2) ? 2 : CLRAW;
  localparam int SMAX  = CLMAX + D + 2;
  localparam int PMAX  = D + 2 + (1 << WR_W) - 1;
  localparam int CMAX  = (SMAX > PMAX) ? SMAX : PMAX;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int DL    = (1 << CL_W) + 3;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ONE = cnt_t'(1);
  localparam cnt_t K2  = cnt_t'(2);
  localparam cnt_t KD  = cnt_t'(D);
  localparam cnt_t KD1 = cnt_t'(D + 1);
  localparam cnt_t KD2 = cnt_t'(D + 2);
  localparam cnt_t KD3 = cnt_t'(D + 3);
  localparam logic [NBANKS-1:0] NB_ONE =
    {{(NBANKS-1){1'b0}}, 1'b1};

  logic              rd, wr, cmd, onehot, coll;
  logic [NBANKS-1:0] bank;
  cnt_t              tcas, cl, twr, tap;
  cnt_t              rs_ld, ws_ld, pc_ld;
  logic [DL-1:0]     tap_oh, shifted;

  cnt_t              rs_q, rs_d;
  cnt_t              ws_q, ws_d;
  cnt_t              dir_q, dir_d;
  cnt_t              pc_q [NBANKS];
  cnt_t              pc_d [NBANKS];
  logic [DL-1:0]     pend_q, pend_d;
  logic              wr_d_q, wr_d_d;
  logic              read_safe_q, read_safe_d;
  logic              write_safe_q, write_safe_d;
  logic [NBANKS-1:0] prech_q, prech_d;
  logic              ack_q, ack_d;
  logic              dir_out_q, dir_out_d;
  logic              dir_r_q, dir_r_d;
  logic              viol_q, viol_d;

  always_comb begin
    rd     = bus.read;
    wr     = bus.write & ~bus.read;
    cmd    = bus.read | bus.write;
    bank   = bus.concerned_bank;
    onehot = (bank != '0) &&
             ((bank & (bank - NB_ONE)) == '0);
    tcas   = cnt_t'(bus.tim_cas);
    cl     = (tcas < K2) ? K2 : tcas;
    twr    = cnt_t'(bus.tim_wr);

    if (rd) begin
      rs_ld = KD2;
      ws_ld = cl + KD2;
      pc_ld = KD;
    end else begin
      rs_ld = (cl < KD3) ? KD3 - cl : ONE;
      ws_ld = KD2;
      pc_ld = KD2 + twr;
    end

    rs_d = (rs_q != '0) ? rs_q - ONE : '0;
    ws_d = (ws_q != '0) ? ws_q - ONE : '0;
    if (cmd) begin
      rs_d = rs_ld;
      ws_d = ws_ld;
    end
    read_safe_d  = (rs_d == '0);
    write_safe_d = (ws_d == '0);

    // merge keeps the longer of pending and new guard time
    for (int n = 0; n < NBANKS; n++) begin
      pc_d[n] = (pc_q[n] != '0) ? pc_q[n] - ONE : '0;
      if (cmd && bank[n] && (pc_ld > pc_d[n]))
        pc_d[n] = pc_ld;
      prech_d[n] = (pc_d[n] == '0);
    end

    tap = rd ? cl + ONE : '0;
    for (int i = 0; i < DL; i++)
      tap_oh[i] = (cnt_t'(i) == tap);
    shifted = pend_q >> 1;
    coll    = cmd & (|(shifted & tap_oh));
    pend_d  = cmd ? (shifted | tap_oh) : shifted;
    ack_d   = pend_q[0];

    wr_d_d = wr;
    if (wr_d_q)
      dir_d = KD1;
    else
      dir_d = (dir_q != '0) ? dir_q - ONE : '0;
    dir_out_d = (dir_d != '0);
    dir_r_d   = wr | (dir_d != '0);

    viol_d = viol_q
           | (bus.read & ~read_safe_q)
           | (bus.write & ~write_safe_q)
           | (bus.read & bus.write)
           | (cmd & ~onehot)
           | coll;
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      rs_q         <= '0;
      ws_q         <= '0;
      dir_q        <= '0;
      for (int n = 0; n < NBANKS; n++)
        pc_q[n] <= '0;
      pend_q       <= '0;
      wr_d_q       <= 1'b0;
      read_safe_q  <= 1'b1;
      write_safe_q <= 1'b1;
      prech_q      <= '1;
      ack_q        <= 1'b0;
      dir_out_q    <= 1'b0;
      dir_r_q      <= 1'b0;
      viol_q       <= 1'b0;
    end else begin
      rs_q         <= rs_d;
      ws_q         <= ws_d;
      dir_q        <= dir_d;
      for (int n = 0; n < NBANKS; n++)
        pc_q[n] <= pc_d[n];
      pend_q       <= pend_d;
      wr_d_q       <= wr_d_d;
      read_safe_q  <= read_safe_d;
      write_safe_q <= write_safe_d;
      prech_q      <= prech_d;
      ack_q        <= ack_d;
      dir_out_q    <= dir_out_d;
      dir_r_q      <= dir_r_d;
      viol_q       <= viol_d;
    end
  end

  assign bus.read_safe      = read_safe_q;
  assign bus.write_safe     = write_safe_q;
  assign bus.precharge_safe = prech_q;
  assign bus.ack            = ack_q;
  assign bus.direction      = dir_out_q;
  assign bus.direction_r    = dir_r_q;
  assign bus.violation      = viol_q;
endmodule

// File: tb/tb_hpdmc_datactl_gen.sv
// Bench for hpdmc_datactl_gen: directed timeline plus
// randomized traffic against an absolute-time model.
module tb_hpdmc_datactl_gen;
  localparam int NB    = 4;
  localparam int BURST = 4;
  localparam int CL_W  = 2;
  localparam int WR_W  = 2;
  localparam int D     = BURST / 2;
  localparam int TMAX  = 2048;

  logic sys_clk     = 1'b0;
  logic sdram_rst_n = 1'b1;
  int   edge_n      = 0;
  int   tests       = 0;
  int   fails       = 0;

  hpdmc_datactl_gen_if #(
    .NBANKS(NB), .CL_W(CL_W), .WR_W(WR_W)
  ) bus ();

  hpdmc_datactl_gen #(
    .NBANKS(NB), .BURST(BURST),
    .CL_W(CL_W), .WR_W(WR_W)
  ) dut (
    .sys_clk(sys_clk),
    .sdram_rst_n(sdram_rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_n <= edge_n + 1;

  // model: absolute edge at which each output is next high
  int rs_at, ws_at;
  int pc_at [NB];
  bit ack_at  [TMAX];
  bit dir_at  [TMAX];
  bit dirr_at [TMAX];
  bit viol;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    rs_at = 0;
    ws_at = 0;
    for (int n = 0; n < NB; n++) pc_at[n] = 0;
    for (int i = 0; i < TMAX; i++) begin
      ack_at[i]  = 1'b0;
      dir_at[i]  = 1'b0;
      dirr_at[i] = 1'b0;
    end
    viol = 1'b0;
  endtask

  task automatic model_cmd(input int t, input bit rd,
                           input bit wr,
                           input logic [NB-1:0] bk,
                           input int cas, input int twr);
    int cl;
    int a;
    bit r;
    cl = (cas < 2) ? 2 : cas;
    r  = rd;
    if (rd || wr) begin
      if (rd && t < rs_at) viol = 1'b1;
      if (wr && t < ws_at) viol = 1'b1;
      if (rd && wr) viol = 1'b1;
      if ($countones(bk) != 1) viol = 1'b1;
      if (r) begin
        rs_at = t + D + 3;
        ws_at = t + cl + D + 3;
      end else begin
        rs_at = t + imax(D + 4 - cl, 2);
        ws_at = t + D + 3;
      end
      for (int n = 0; n < NB; n++)
        if (bk[n])
          pc_at[n] = imax(pc_at[n],
            r ? t + D + 1 : t + D + 3 + twr);
      a = r ? t + cl + 3 : t + 2;
      if (ack_at[a]) viol = 1'b1;
      ack_at[a] = 1'b1;
      if (!r) begin
        for (int c = t + 1; c <= t + D + 2; c++)
          dirr_at[c] = 1'b1;
        for (int c = t + 2; c <= t + D + 2; c++)
          dir_at[c] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b edge=%0d",
             tag, obs, exp, edge_n + 1);
    end
  endtask

  task automatic chkv(input string tag,
                      input logic [NB-1:0] obs,
                      input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b edge=%0d",
             tag, obs, exp, edge_n + 1);
    end
  endtask

  task automatic check_model(input int k);
    logic [NB-1:0] pc;
    for (int n = 0; n < NB; n++) pc[n] = (k >= pc_at[n]);
    chk("read_safe", bus.read_safe, k >= rs_at);
    chk("write_safe", bus.write_safe, k >= ws_at);
    chkv("precharge_safe", bus.precharge_safe, pc);
    chk("ack", bus.ack, ack_at[k]);
    chk("direction", bus.direction, dir_at[k]);
    chk("direction_r", bus.direction_r, dirr_at[k]);
    chk("violation", bus.violation, viol);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rs"}, bus.read_safe, 1'b1);
    chk({tag, "_ws"}, bus.write_safe, 1'b1);
    chkv({tag, "_pc"}, bus.precharge_safe, '1);
    chk({tag, "_ack"}, bus.ack, 1'b0);
    chk({tag, "_dir"}, bus.direction, 1'b0);
    chk({tag, "_dirr"}, bus.direction_r, 1'b0);
    chk({tag, "_viol"}, bus.violation, 1'b0);
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input bit rd, input bit wr,
                      input logic [NB-1:0] bk);
    int k;
    k = edge_n + 1;
    if (sdram_rst_n) check_model(k);
    bus.read           = rd;
    bus.write          = wr;
    bus.concerned_bank = bk;
    @(posedge sys_clk);
    if (sdram_rst_n)
      model_cmd(k, rd, wr, bk,
                int'(bus.tim_cas), int'(bus.tim_wr));
    @(negedge sys_clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic idle_to(input int k);
    while (edge_n + 1 < k) step(1'b0, 1'b0, 4'b0001);
  endtask

  task automatic rand_phase(input int n, input bit wild);
    int k, r;
    logic [NB-1:0] bk;
    for (int i = 0; i < n; i++) begin
      k  = edge_n + 1;
      bus.tim_cas = CL_W'($urandom_range(0, 3));
      bus.tim_wr  = WR_W'($urandom_range(0, 3));
      bk = NB'(1) << $urandom_range(0, NB - 1);
      r  = $urandom_range(0, 99);
      if (wild && r < 8)
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             NB'($urandom_range(0, (1 << NB) - 1)));
      else if (r < 35 && k >= rs_at)
        step(1'b1, 1'b0, bk);
      else if (r < 65 && k >= ws_at)
        step(1'b0, 1'b1, bk);
      else
        step(1'b0, 1'b0, bk);
    end
  endtask

  logic [9:0] dir_pat;

  initial begin
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    bus.concerned_bank = 4'b0001;
    bus.tim_cas        = 2'd3;
    bus.tim_wr         = 2'd2;
    model_reset();
    #1 sdram_rst_n = 1'b0;
    #1 check_reset("init");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sdram_rst_n = 1'b1;

    idle_to(10);
    step(1'b0, 1'b1, 4'b0001);
    chk("tp1_rs11", bus.read_safe, 1'b0);
    chk("tp1_dirr11", bus.direction_r, 1'b1);
    chk("tp1_dir11", bus.direction, 1'b0);
    idle_to(12);
    chk("tp1_ack12", bus.ack, 1'b1);
    chk("tp1_dir12", bus.direction, 1'b1);
    idle_to(13);
    chk("tp1_rs13", bus.read_safe, 1'b1);
    idle_to(14);
    chk("tp1_dir14", bus.direction, 1'b1);
    chk("tp1_ws14", bus.write_safe, 1'b0);
    idle_to(15);
    chk("tp1_dir15", bus.direction, 1'b0);
    chk("tp1_dirr15", bus.direction_r, 1'b0);
    chk("tp1_ws15", bus.write_safe, 1'b1);

    idle_to(20);
    step(1'b1, 1'b0, 4'b0001);
    chkv("tp2_pc21", bus.precharge_safe, 4'b1110);
    idle_to(22);
    chkv("tp2_pc22", bus.precharge_safe, 4'b1110);
    idle_to(23);
    chkv("tp2_pc23", bus.precharge_safe, 4'b1111);
    idle_to(24);
    chk("tp2_rs24", bus.read_safe, 1'b0);
    idle_to(25);
    chk("tp2_rs25", bus.read_safe, 1'b1);
    chk("tp2_ack25", bus.ack, 1'b0);
    idle_to(26);
    chk("tp2_ack26", bus.ack, 1'b1);
    idle_to(27);
    chk("tp2_ws27", bus.write_safe, 1'b0);
    idle_to(28);
    chk("tp2_ws28", bus.write_safe, 1'b1);

    idle_to(30);
    step(1'b0, 1'b1, 4'b0100);
    idle_to(33);
    bus.tim_cas = 2'd2;
    step(1'b1, 1'b0, 4'b0100);
    idle_to(36);
    chk("tp3_pc36", bus.precharge_safe[2], 1'b0);
    idle_to(37);
    chk("tp3_pc37", bus.precharge_safe[2], 1'b1);
    chk("tp3_viol", bus.violation, 1'b0);

    idle_to(40);
    bus.tim_cas = 2'd3;
    step(1'b0, 1'b1, 4'b0001);
    dir_pat = 10'b0111001110;
    for (int k = 41; k <= 49; k++) begin
      chk("tp4_dir", bus.direction, dir_pat[k - 41]);
      if (k == 42 || k == 47)
        chk("tp4_ack", bus.ack, 1'b1);
      step(1'b0, k == 45, 4'b0010);
    end
    chk("tp4_dir50", bus.direction, 1'b0);

    step(1'b1, 1'b0, 4'b0001);
    idle_to(52);
    chk("tp5_v52", bus.violation, 1'b0);
    chk("tp5_rs52", bus.read_safe, 1'b0);
    step(1'b1, 1'b0, 4'b0001);
    chk("tp5_v53", bus.violation, 1'b1);

    idle_to(58);
    step(1'b1, 1'b0, 4'b0001);
    idle_to(61);
    step(1'b0, 1'b1, 4'b0001);
    idle_to(63);
    chk("tp6_dir63", bus.direction, 1'b1);
    chk("tp5_v63", bus.violation, 1'b1);
    #2 sdram_rst_n = 1'b0;
    #1 check_reset("tp6_async");
    model_reset();
    @(posedge sys_clk);
    #1 chk("tp6_ack63", bus.ack, 1'b0);
    @(posedge sys_clk);
    #1 chk("tp6_ack64", bus.ack, 1'b0);
    @(negedge sys_clk);
    sdram_rst_n = 1'b1;
    idle_to(72);

    rand_phase(400, 1'b0);

    #2 sdram_rst_n = 1'b0;
    #1 check_reset("mid_rst");
    model_reset();
    @(negedge sys_clk);
    sdram_rst_n = 1'b1;
    rand_phase(400, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
